// File: rtl/adder_pipe_param_if.sv
// Handshake and data bundle for adder_pipe_param.
// The master drives the operands and downstream ready. The slave returns the result and the flags.
interface adder_pipe_param_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  i_en;
  logic                  i_rdy;
  logic                  i_sub;
  logic                  i_cin;
  logic [DATA_WIDTH-1:0] adda;
  logic [DATA_WIDTH-1:0] addb;
  logic [DATA_WIDTH:0]   result;
  logic                  o_ovf;
  logic                  o_en;
  logic                  o_rdy;

  modport master (
    output i_en, i_sub, i_cin, adda, addb, o_rdy,
    input  i_rdy, result, o_ovf, o_en
  );

  modport slave (
    input  i_en, i_sub, i_cin, adda, addb, o_rdy,
    output i_rdy, result, o_ovf, o_en
  );
endinterface

// File: rtl/adder_pipe_param.sv
// Pipelined add/subtract unit. Each register stage resolves one STG_WIDTH chunk.
// The whole pipeline freezes while the output is valid and not accepted downstream.
module adder_pipe_param #(
  parameter int DATA_WIDTH = 64,
  parameter int STG_WIDTH  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  adder_pipe_param_if.slave  bus
);
  localparam int NUM_STG = DATA_WIDTH / STG_WIDTH;
  localparam int MSB     = DATA_WIDTH - 1;

  // Stage inputs: index 0 comes from the ports, and index s comes from the registers of stage s-1.
  logic                  pv   [NUM_STG];
  logic                  psub [NUM_STG];
  logic                  pc   [NUM_STG];
  logic [DATA_WIDTH-1:0] pa   [NUM_STG];
  logic [DATA_WIDTH-1:0] pb   [NUM_STG];
  logic [DATA_WIDTH-1:0] psum [NUM_STG];

  logic stall;
  logic advance;

  assign stall     = bus.o_en && !bus.o_rdy;
  assign advance   = !stall;
  assign bus.i_rdy = !stall;

  // Subtract is A + ~B + !borrow_in, so B is inverted and the carry seed is flipped here, once.
  assign pv[0]   = bus.i_en && !stall;
  assign psub[0] = bus.i_sub;
  assign pc[0]   = bus.i_sub ^ bus.i_cin;
  assign pa[0]   = bus.adda;
  assign pb[0]   = bus.i_sub ? ~bus.addb : bus.addb;
  assign psum[0] = '0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STG; gi++) begin : g_stg
      logic                  v_q,   v_d;
      logic                  sub_q, sub_d;
      logic                  c_q,   c_d;
      logic [DATA_WIDTH-1:0] a_q,   a_d;
      logic [DATA_WIDTH-1:0] b_q,   b_d;
      logic [DATA_WIDTH-1:0] sum_q, sum_d;

      always_comb begin
        v_d   = v_q;
        sub_d = sub_q;
        c_d   = c_q;
        a_d   = a_q;
        b_d   = b_q;
        sum_d = sum_q;
        if (advance) begin
          v_d   = pv[gi];
          sub_d = psub[gi];
          a_d   = pa[gi];
          b_d   = pb[gi];
          sum_d = psum[gi];
          {c_d, sum_d[gi*STG_WIDTH +: STG_WIDTH]} =
              {1'b0, pa[gi][gi*STG_WIDTH +: STG_WIDTH]}
            + {1'b0, pb[gi][gi*STG_WIDTH +: STG_WIDTH]}
            + {{STG_WIDTH{1'b0}}, pc[gi]};
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q   <= 1'b0;
          sub_q <= 1'b0;
          c_q   <= 1'b0;
          a_q   <= '0;
          b_q   <= '0;
          sum_q <= '0;
        end else begin
          v_q   <= v_d;
          sub_q <= sub_d;
          c_q   <= c_d;
          a_q   <= a_d;
          b_q   <= b_d;
          sum_q <= sum_d;
        end
      end

      if (gi < NUM_STG - 1) begin : g_fwd
        assign pv[gi+1]   = v_q;
        assign psub[gi+1] = sub_q;
        assign pc[gi+1]   = c_q;
        assign pa[gi+1]   = a_q;
        assign pb[gi+1]   = b_q;
        assign psum[gi+1] = sum_q;
      end else begin : g_out
        // For subtract, the top bit reports a borrow, which is the inverted carry-out.
        assign bus.o_en   = v_q;
        assign bus.result = {sub_q ^ c_q, sum_q};
        assign bus.o_ovf  = (a_q[MSB] == b_q[MSB]) && (sum_q[MSB] != a_q[MSB]);
      end
    end
  endgenerate
endmodule

// File: doc/adder_pipe_param.md
Name: adder_pipe_param

Overview:
Parametrised pipelined adder/subtractor, successor to the fixed 64-bit pipelined adder. Splits the operands into STG_WIDTH chunks and resolves one chunk per register stage. Adds subtract mode, carry/borrow-in, a signed-overflow flag and output backpressure. Sits in the datapath wherever a wide add/sub must close timing at full clock rate.

Parameters:
DATA_WIDTH, 64, operand width in bits; must be an integer multiple of STG_WIDTH.
STG_WIDTH, 16, bits resolved per pipeline stage.
NUM_STG, DATA_WIDTH/STG_WIDTH, derived localparam; pipeline depth. Not overridable.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
i_en  input  1  input valid.
i_rdy  output  1  input ready; a transfer occurs when i_en && i_rdy at a rising edge.
i_sub  input  1  0 = add, 1 = subtract.
i_cin  input  1  carry-in for add; borrow-in for subtract.
adda  input  DATA_WIDTH  operand A.
addb  input  DATA_WIDTH  operand B.
result  output  DATA_WIDTH+1  {carry/borrow, sum}.
o_ovf  output  1  two's-complement signed overflow of the sum.
o_en  output  1  output valid.
o_rdy  input  1  downstream ready; output is consumed when o_en && o_rdy at a rising edge.

Behaviour:
- Reset (rst_n low, asynchronous): every stage valid bit clears, and all data and carry registers clear. Outputs: o_en=0, result=0, o_ovf=0. i_rdy=1 whenever o_en=0, including during reset. In-flight transactions are discarded, not completed.
- Arithmetic:
  - Add: sum = A + B + i_cin.
  - Subtract: sum = A + ~B + !i_cin, which equals A - B - i_cin.
  - result[DATA_WIDTH-1:0] = sum mod 2^DATA_WIDTH.
  - Add: result[DATA_WIDTH] = carry-out.
  - Subtract: result[DATA_WIDTH] = borrow = inverted carry-out. It is 1 iff A < B + i_cin (unsigned).
  - o_ovf = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]), where B' = i_sub ? ~B : B.
- Pipeline:
  - Stage s (1..NUM_STG) registers chunk s-1 sum and its carry-out. Lower chunks already summed are carried forward, and upper operand chunks, i_sub and the MSBs needed for o_ovf are delayed alongside.
  - No combinational carry chain longer than STG_WIDTH bits.
- Latency: a transaction accepted at edge t is presented with o_en=1 after edge t+NUM_STG-1. That is, i_en high in cycle 0 gives o_en high in cycle NUM_STG-1+1 = NUM_STG edges after presentation. Default: 4 cycles.
- Throughput: one transaction per cycle while o_rdy=1. Results leave in acceptance order.
- Backpressure:
  - Global stall: stall = o_en && !o_rdy.
  - During stall, every stage register, valid bit and output holds; result, o_ovf and o_en are stable.
  - i_rdy = !stall (combinational from o_rdy and o_en).
  - If i_en=1 while i_rdy=0, no transfer occurs; the source must hold its data.
- Bubbles: stage valid bits propagate with the data. Invalid stages advance normally when not stalled. result and o_ovf are don't-care when o_en=0 but must not be X after reset.
- Simultaneous input accept and output consume in the same edge is legal and loses nothing.
- NUM_STG=1 (STG_WIDTH=DATA_WIDTH): degenerates to a single registered adder with 1-cycle latency. Same handshake rules apply.

Test Plan:
- Add carry-out (defaults): A=0xFFFF_FFFF_FFFF_FFFF, B=0, cin=1, sub=0 -> result=0x1_0000_0000_0000_0000, o_ovf=0, o_en exactly 4 cycles after i_en.
- Signed overflow: add A=0x7FFF_FFFF_FFFF_FFFF, B=1, cin=0 -> result=0x0_8000_0000_0000_0000, o_ovf=1. Subtract A=0x8000_0000_0000_0000, B=1 -> result=0x0_7FFF_FFFF_FFFF_FFFF, o_ovf=1.
- Borrow: sub A=0, B=1, cin=0 -> result=0x1_FFFF_FFFF_FFFF_FFFF, o_ovf=0. Sub A=5, B=3, cin=1 -> result=0x0_0000_0000_0000_0001.
- Streaming with stall: 8 back-to-back random add/sub ops with o_rdy low for 3 cycles mid-stream -> i_rdy low exactly while o_en && !o_rdy, output held stable, all 8 results correct, in order, none duplicated or dropped.
- Reset mid-operation: 3 transactions in flight, rst_n pulsed low -> o_en=0, result=0 immediately. After release, no stale output appears, and a new op completes in 4 cycles.
- Reparametrised (DATA_WIDTH=32, STG_WIDTH=8): A=0xFFFF_FFFF, B=1 add -> result=0x1_0000_0000, o_en exactly 4 cycles later. STG_WIDTH=32 -> 1-cycle latency, same result.
